tdt_dmi_sync_hs_rsp: RTL

Destination-side responder of a four-phase req/ack clock-domain-crossing handshake for DMI traffic. It synchronizes an asynchronous request level from the source domain, captures the source's held-stable data bus, and presents it as a valid/ready transfer in the dst_clk domain. On acceptance it returns a registered acknowledge level to the source and waits for the request to fall before re-arming. It is the receiving end paired with a source-side handshake initiator on the DMI path.

---
 rtl/tdt_dmi_sync_hs_rsp.sv | 106 ++++++++++
 1 files changed

// File: rtl/tdt_dmi_sync_hs_rsp.sv
// Destination-side responder of a four-phase req/ack CDC handshake for DMI
// traffic. The request level from the source domain is synchronized, the
// source's held-stable payload is captured once per request, and the payload
// is offered downstream as a valid/ready transfer in the dst_clk domain.
//
// Handshake rules (downstream side): dst_data is offered while dst_vld is high
// and is consumed on a rising dst_clk edge where dst_vld && dst_rdy; dst_vld and
// dst_data stay stable until that edge. Source side: four-phase, where src_req
// rises, the responder raises dst_ack once the word has been consumed, src_req
// falls, and dst_ack falls once the falling request has been synchronized.
module tdt_dmi_sync_hs_rsp #(
    parameter int unsigned DATA_WIDTH = 41,
    parameter int unsigned SYNC_NUM   = 2   // synchronizer depth, must be >= 2
) (
    input  logic                  dst_clk,
    input  logic                  dst_rst_b,
    input  logic                  src_req,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dst_ack,
    output logic                  dst_vld,
    output logic [DATA_WIDTH-1:0] dst_data,
    input  logic                  dst_rdy,
    output logic                  dst_busy,
    output logic [1:0]            dbg_state
);

    // State encoding: bit 0 is the VALID flag and bit 1 the ACK flag, so both
    // outputs come straight from state flops with no decode glitches.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_VALID = 2'b01;
    localparam logic [1:0] ST_ACK   = 2'b10;

    logic [SYNC_NUM-1:0]   sync_q;
    logic                  req_s;
    logic [1:0]            state_q;
    logic [1:0]            state_nxt;
    logic                  load_data;
    logic [DATA_WIDTH-1:0] data_q;

    // Request synchronizer: the only logic that touches the asynchronous src_req.
    always_ff @(posedge dst_clk or negedge dst_rst_b) begin
        if (!dst_rst_b) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_NUM-2:0], src_req};
        end
    end

    assign req_s = sync_q[SYNC_NUM-1];

    // Next-state decode. A request that rises again while still in ACK is
    // ignored: ACK only exits once req_s has been seen low. A request that
    // drops while VALID does not abort the transfer; ACK is still entered and
    // held for at least one cycle before returning to IDLE.
    always_comb begin
        state_nxt = state_q;
        load_data = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt = ST_VALID;
                    load_data = 1'b1;
                end
            end
            ST_VALID: begin
                if (dst_rdy) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge dst_clk or negedge dst_rst_b) begin
        if (!dst_rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Payload capture: src_data is sampled only on the IDLE -> VALID step,
    // when the source guarantees it is stable.
    always_ff @(posedge dst_clk or negedge dst_rst_b) begin
        if (!dst_rst_b) begin
            data_q <= '0;
        end else if (load_data) begin
            data_q <= src_data;
        end
    end

    assign dst_vld   = state_q[0];
    assign dst_ack   = state_q[1];
    assign dst_data  = data_q;
    assign dst_busy  = state_q != ST_IDLE;
    assign dbg_state = state_q;

endmodule
